// File: rtl/prog_loader.sv
// Host-side program loader: streams external words into memory, holds the CPU
// until the load completes, and offers a handshaked readback of memory contents.
module prog_loader #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] HLT_WORD = 16'hE001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_we,
  input  logic [DATA_W-1:0] ext_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, LOAD, DONE, RD_ADDR, RD_WAIT, RD_OUT} state_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic                halt_pend_q, halt_pend_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    halt_pend_d  = halt_pend_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    overflow_d   = overflow_q;
    rd_ptr_d     = rd_ptr_q;
    rem_d        = rem_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    case (state_q)
      IDLE, LOAD: begin
        // HLT is written first; the pending cycle keeps load_done one cycle
        // after the final write pulse, matching the gap-terminated case.
        if (state_q == LOAD && (halt_pend_q || !ext_we)) begin
          state_d     = DONE;
          halt_pend_d = 1'b0;
          load_done_d = 1'b1;
          cpu_hold_d  = 1'b0;
        end else if (ext_we) begin
          state_d = LOAD;
          if (wr_ptr_q < DEPTH) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
            mem_wdata_d = ext_data;
            wr_ptr_d    = wr_ptr_q + ONE;
          end else begin
            overflow_d = 1'b1;
          end
          if (ext_data == HLT_WORD) halt_pend_d = 1'b1;
        end
      end
      DONE: begin
        if (rd_start && rd_len != '0) begin
          rd_ptr_d   = rd_base;
          rem_d      = rd_len;
          mem_addr_d = rd_base;
          cpu_hold_d = 1'b1;
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: begin
        mem_addr_d = rd_ptr_q;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        dump_data_d  = mem_rdata;
        dump_valid_d = 1'b1;
        state_d      = RD_OUT;
      end
      RD_OUT: begin
        if (dump_ready) begin
          rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
          rem_d        = rem_q - ONE;
          dump_valid_d = 1'b0;
          if (rem_q == ONE) begin
            cpu_hold_d = 1'b0;
            state_d    = DONE;
          end else begin
            // Present the next address early so the read data lands in RD_WAIT.
            mem_addr_d = rd_ptr_q + ADDR_W'(1);
            state_d    = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d inside {LOAD, RD_ADDR, RD_WAIT, RD_OUT});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      halt_pend_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rd_ptr_q     <= '0;
      rem_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      halt_pend_q  <= halt_pend_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
      rd_ptr_q     <= rd_ptr_d;
      rem_q        <= rem_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_count = wr_ptr_q;
  assign overflow   = overflow_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: random loads/readbacks against an array model
// of memory, with a decoupled monitor popping expected writes and dump words.
module tb_prog_loader;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] HLT = 16'hE001;

  logic clk = 1'b0, rst = 1'b1, ext_we = 1'b0, rd_start = 1'b0, dump_ready = 1'b0;
  logic [DW-1:0] ext_data = '0;
  logic [AW-1:0] rd_base = '0;
  logic [AW:0]   rd_len = '0;
  logic          mem_we, cpu_hold, load_done, overflow, dump_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, dump_data;
  logic [AW:0]   load_count;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;

  typedef struct {int addr; logic [DW-1:0] data;} wr_t;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_dump[$];

  int checks = 0, failures = 0, cyc = 0;
  int last_we_cyc = 0, last_hs_cyc = 0;
  bit chk_ld_lat = 0, chk_tput = 0, hs_seen = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_ld = 1'b0;
  logic [DW-1:0] prev_data = '0;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .HLT_WORD(HLT)) dut (
    .clk(clk), .rst(rst), .ext_we(ext_we), .ext_data(ext_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_count(load_count), .overflow(overflow),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data valid the cycle after the address
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w = DW'($urandom);
    if (w == HLT) w = '0;
    return w;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write or a dump word
  initial forever begin
    wr_t w;
    @(negedge clk);
    if (rst) begin
      prev_valid = 1'b0;
      prev_ld    = 1'b0;
    end else begin
      if (mem_we) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), w.addr);
          chk("wr_data", 32'(mem_wdata), 32'(w.data));
        end
        last_we_cyc = cyc;
      end
      if (load_done && !prev_ld && chk_ld_lat) begin
        chk("done_latency", cyc - last_we_cyc, 32'd1);
        chk("hold_at_done", 32'(cpu_hold), 32'd0);
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", 32'(dump_valid), 32'd1);
        chk("stall_data", 32'(dump_data), 32'(prev_data));
      end
      if (dump_valid) chk("hold_in_dump", 32'(cpu_hold), 32'd1);
      if (dump_valid && dump_ready) begin
        chk("dump_expected", 32'(exp_dump.size() != 0), 32'd1);
        if (exp_dump.size() != 0) chk("dump_data", 32'(dump_data), 32'(exp_dump.pop_front()));
        if (chk_tput && hs_seen) chk("dump_spacing", cyc - last_hs_cyc, 32'd3);
        hs_seen     = 1;
        last_hs_cyc = cyc;
      end
      prev_valid = dump_valid;
      prev_ready = dump_ready;
      prev_data  = dump_data;
      prev_ld    = load_done;
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1; ext_we = 1'b0; rd_start = 1'b0; dump_ready = 1'b0;
    exp_wr.delete(); exp_dump.delete();
    chk_tput = 0; chk_ld_lat = 0;
    repeat (n) tick();
    chk("rst_flags", 32'({mem_we, cpu_hold, load_done, overflow, dump_valid, busy}), 32'b010000);
    chk("rst_count_addr", 32'({load_count, mem_addr}), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_dump_data", 32'(dump_data), 32'd0);
    rst = 1'b0;
  endtask

  // Model: words are written in order until HLT (inclusive) or memory full
  task automatic do_load(input logic [DW-1:0] ws[$], input int extra);
    int ptr = 0;
    int t = 0;
    bit ovf = 0, halted = 0;
    foreach (ws[i]) begin
      if (!halted) begin
        if (ptr < DEPTH) begin
          exp_wr.push_back('{ptr, ws[i]});
          ref_mem[ptr] = ws[i];
          ptr++;
        end else ovf = 1;
        if (ws[i] == HLT) halted = 1;
      end
    end
    chk_ld_lat = !ovf;
    foreach (ws[i]) begin
      ext_we = 1'b1; ext_data = ws[i]; tick();
    end
    ext_we = 1'b0; tick();
    while (!load_done && t < 20) begin tick(); t++; end
    chk("load_done", 32'(load_done), 32'd1);
    chk("load_count", 32'(load_count), ptr);
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("hold_released", 32'({cpu_hold, busy}), 32'd0);
    repeat (extra) begin
      ext_we = 1'b1; ext_data = DW'($urandom); tick();
    end
    ext_we = 1'b0; tick();
    chk("count_after_ignored", 32'(load_count), ptr);
    chk("overflow_sticky", 32'(overflow), 32'(ovf));
    chk_ld_lat = 0;
  endtask

  // mode 0: ready high, 1: ready toggles every 2 cycles, 2: random ready
  task automatic do_read(input int base, input int len, input int mode);
    int t = 0;
    for (int i = 0; i < len; i++) exp_dump.push_back(ref_mem[(base + i) % DEPTH]);
    hs_seen = 0; chk_tput = (mode == 0);
    rd_base = AW'(base); rd_len = (AW+1)'(len); rd_start = 1'b1;
    dump_ready = (mode == 0);
    tick();
    rd_start = 1'b0;
    if (len == 0) begin
      repeat (3) begin chk("noop_busy", 32'(busy), 32'd0); tick(); end
      chk("noop_hold", 32'({cpu_hold, dump_valid}), 32'd0);
    end else begin
      chk("hold_in_read", 32'({cpu_hold, busy}), 32'b11);
      while ((exp_dump.size() != 0 || busy) && t < 300) begin
        case (mode)
          0:       dump_ready = 1'b1;
          1:       dump_ready = ((t / 2) % 2) == 1;
          default: dump_ready = 1'($urandom_range(0, 1));
        endcase
        tick(); t++;
      end
      chk("read_finished", 32'(exp_dump.size() == 0 && !busy), 32'd1);
      chk("hold_after_read", 32'(cpu_hold), 32'd0);
      dump_ready = 1'b0;
    end
    chk_tput = 0;
  endtask

  initial begin
    logic [DW-1:0] ws[$];
    int t;
    for (int i = 0; i < DEPTH; i++) begin
      pre_we = 1'b1; pre_a = AW'(i); pre_d = DW'($urandom);
      ref_mem[i] = pre_d;
      tick();
    end
    pre_we = 1'b0;

    do_reset(9);
    rd_base = 3'd1; rd_len = 4'd2; rd_start = 1'b1; tick(); rd_start = 1'b0; tick();
    chk("idle_rd_ignored", 32'({busy, dump_valid, cpu_hold}), 32'b001);

    ws = '{16'h18A0, 16'h19C0, 16'h0204, 16'h2AE0, 16'hE001, 16'h1111};
    do_load(ws, 2);
    do_read(2, 3, 0);
    do_read(5, 0, 0);

    do_reset(2);
    ws = '{rnd_word(), rnd_word(), rnd_word()};
    do_load(ws, 1);
    ext_we = 1'b1; ext_data = 16'h1234; tick(); ext_we = 1'b0; tick();
    chk("done_ignores_1234", 32'(load_count), 32'd3);
    do_read(1, 2, 1);

    do_reset(1);
    ws.delete();
    for (int i = 0; i < DEPTH + 2; i++) ws.push_back(rnd_word());
    do_load(ws, 0);
    do_read(DEPTH - 1, 2, 1);
    do_read(int'($urandom_range(0, DEPTH - 1)), DEPTH, 2);

    // Reset while a dump word is stalled
    rd_base = '0; rd_len = 4'd3; rd_start = 1'b1; dump_ready = 1'b0; tick(); rd_start = 1'b0;
    t = 0;
    while (!dump_valid && t < 10) begin tick(); t++; end
    chk("stalled_valid", 32'(dump_valid), 32'd1);
    rst = 1'b1; tick();
    chk("abort_state", 32'({dump_valid, cpu_hold, busy, load_done}), 32'b0100);
    do_reset(1);
    tick();
    chk("idle_after_abort", 32'({busy, load_done, cpu_hold}), 32'b001);

    for (int it = 0; it < 6; it++) begin
      do_reset(int'($urandom_range(1, 3)));
      ws.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++)
        ws.push_back(($urandom_range(0, 5) == 0) ? HLT : rnd_word());
      do_load(ws, int'($urandom_range(0, 3)));
      for (int r = 0; r < 2; r++)
        do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side loader for the Risc instruction/data memory.
- Receives the external word stream (ext_we/ext_data) and writes it into memory at auto-incrementing addresses.
- Holds the CPU in reset until the load is complete.
- Also provides a block readback path, with valid/ready handshake, that streams memory contents back to the host after a run.

Parameters:
ADDR_W, 8, memory address width; depth = 2**ADDR_W words
DATA_W, 16, word width
HLT_WORD, 16'hE001, encoding of HLT; writing it ends a load early

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
ext_we  in  1  external write strobe; one word per cycle while high
ext_data  in  DATA_W  external word, sampled when ext_we=1
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  memory address, shared by write and read (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_addr is presented
cpu_hold  out  1  active-high CPU reset/hold; high from reset until load_done
load_done  out  1  level; load finished
load_count  out  ADDR_W+1  number of words written in the current load
overflow  out  1  sticky; a write was attempted past the last address
rd_start  in  1  one-cycle pulse; start readback (accepted only in DONE)
rd_base  in  ADDR_W  readback start address, sampled with rd_start
rd_len  in  ADDR_W+1  readback word count, sampled with rd_start; 0 = no-op
dump_valid  out  1  readback word available
dump_data  out  DATA_W  readback word
dump_ready  in  1  host accepts the word when dump_valid and dump_ready are both 1
busy  out  1  high in LOAD, RD_ADDR, RD_WAIT, RD_OUT

Behaviour:
- Reset values:
  - state=IDLE, wr_ptr=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_count=0, overflow=0.
  - dump_valid=0, dump_data=0, busy=0.
- Reset mid-operation aborts any load or readback. Memory contents are not cleared.
- IDLE: on ext_we=1, go to LOAD and write the first word in that cycle's registered output (see LOAD).
- LOAD, each cycle with ext_we=1:
  - If wr_ptr < 2**ADDR_W: next cycle mem_we=1, mem_addr=wr_ptr, mem_wdata=ext_data; wr_ptr++, load_count++. Write latency is 1 cycle.
  - Otherwise: no write, overflow <= 1.
  - If ext_data == HLT_WORD: the word is written, then DONE, and further ext_we is ignored until reset.
- LOAD, ext_we=0: go to DONE. mem_we=0 on the following cycle. A one-cycle gap ends the load.
- DONE entry: load_done=1 and cpu_hold=0 on the same edge, one cycle after the last mem_we pulse.
- DONE: ext_we is ignored (no write, no overflow). cpu_hold stays 0.
- DONE, rd_start=1:
  - If rd_len=0: stay in DONE.
  - Otherwise: latch rd_base into the read pointer and rd_len into a remaining-count; cpu_hold <= 1 (CPU frozen during readback); go to RD_ADDR.
- rd_start outside DONE is ignored.
- RD_ADDR: mem_addr=rd_ptr, mem_we=0; go to RD_WAIT.
- RD_WAIT: capture mem_rdata into dump_data; dump_valid <= 1; go to RD_OUT.
- RD_OUT:
  - dump_data is held stable while dump_valid=1 and dump_ready=0.
  - On handshake: rd_ptr++ (wraps modulo 2**ADDR_W), remaining--.
  - If remaining becomes 0: dump_valid <= 0, cpu_hold <= 0, go to DONE.
  - Otherwise: dump_valid <= 0 and go to RD_ADDR.
- Throughput: one word per 3 cycles with dump_ready tied high.
- mem_we is never 1 in any RD_* state.
- load_count saturates at 2**ADDR_W.
- A new load is possible only after rst.

Test Plan:
1. rst high 9 cycles, then 5 consecutive ext_we words (e.g. 0x18A0, 0x19C0, 0x0204, 0x2AE0, 0xE001) -> mem_we pulses at addresses 0..4 with matching data; load_done=1 and cpu_hold=0 one cycle after address 4; load_count=5.
2. 3 words with no HLT, then ext_we=0 -> DONE after 3 writes; further ext_we=1 with 0x1234 produces no mem_we and leaves load_count=3.
3. ADDR_W=2, 6 words with no HLT -> writes to addresses 0..3 only; overflow=1 and sticky; load_count=4.
4. Memory model preloaded; rd_start with rd_base=2, rd_len=3, dump_ready=1 -> dump_data shows words 2, 3, 4 in order, each dump_valid pulse 1 cycle, 3 cycles apart; cpu_hold is 1 during the dump and 0 after.
5. Readback with dump_ready toggling 0/1 every 2 cycles; rd_base=3, rd_len=2 with ADDR_W=2 -> words 3 then 0 (address wrap); dump_data stable while stalled.
6. rst asserted during RD_OUT -> next cycle dump_valid=0, cpu_hold=1, state IDLE; rd_start with rd_len=0 in DONE -> no state change.
